coeff_ram_bank: RTL and testbench
=================================

Name: coeff_ram_bank

Overview:
Coefficient store that responds to the FIR controller's RAM control bus. It holds four single-port banks of 10 x 16-bit coefficients, 40 taps total. Banks are written during coefficient update and read each cycle during filter operation. Read data is presented to the MAC datapath with a one-cycle registered latency. Per-bank status tells firmware when the coefficient set is complete and whether any address was invalid.

Parameters:
DATA_W, 16, coefficient width (signed two's complement, stored unchanged)
DEPTH, 10, words per bank (valid addresses 0..DEPTH-1)
NUM_BANK, 4, number of banks; bank i uses slice [4i+3:4i] of the address bus
ADDR_W, 4, per-bank address width

Ports:
iClk12M  in  1  12 MHz system clock
iRsn  in  1  asynchronous active-low reset
iCsnRam  in  4  per-bank chip select, active low
iWrnRam  in  4  per-bank write enable, active low (meaningful only with Csn=0)
iAddrRam  in  16  four packed 4-bit bank addresses
iWrDt  in  16  write data, shared by all banks
iClrStat  in  1  synchronous single-cycle pulse: clears load bitmap and error flags
oRdDt  out  64  four packed 16-bit read words, bank i at [16i+15:16i]
oRdValid  out  4  per-bank read-data-valid
oBankFull  out  4  bank i has had all DEPTH locations written since last clear
oAddrErr  out  4  sticky flag: bank i was accessed with address >= DEPTH

Behaviour:
- Reset (iRsn=0, async): all memory words = 0; oRdDt = 0; oRdValid = 0; oBankFull = 0; oAddrErr = 0; internal load bitmaps = 0.
- Per-bank access decode, evaluated each rising edge (bank i):
  - IDLE: Csn=1. No access. oRdValid[i] <= 0. oRdDt slice holds its last value.
  - WRITE: Csn=0, Wrn=0, addr < DEPTH. mem[addr] <= iWrDt; load bit[addr] <= 1. oRdValid[i] <= 0. oRdDt slice holds.
  - READ: Csn=0, Wrn=1, addr < DEPTH. oRdDt slice <= mem[addr] on the same edge. oRdValid[i] <= 1. Data is therefore visible one cycle after the request.
  - BAD: Csn=0, addr >= DEPTH (10..15). A write is discarded. A read returns 0 with oRdValid[i]=1. oAddrErr[i] <= 1.
- Read latency is exactly 1 cycle. Back-to-back reads on consecutive cycles give one word per cycle.
- Write followed by a read of the same address on the next cycle returns the new data. There is no bypass within the same cycle, and none is needed because each bank is single-port.
- oBankFull[i] is registered: set on the edge after the last unwritten location's load bit becomes 1. Rewriting an already-loaded address has no effect on it.
- iClrStat=1 clears the load bitmaps, oBankFull and oAddrErr on that edge. Memory contents are kept.
- Simultaneous iClrStat and WRITE: the clear wins for status, so the load bit ends at 0. The data write still occurs.
- Simultaneous iClrStat and BAD: oAddrErr ends at 0 (clear wins).
- Banks are fully independent. All four may read, write or idle in the same cycle with different addresses.
- Reset asserted mid-burst: all outputs return to reset values immediately. The first access after reset release behaves as from a clean state.
- Inputs are synchronous to iClk12M. There is no internal synchroniser.

Decomposition:
- Shared package fir_pkg holds:
  - DATA_W, DEPTH, NUM_BANK, ADDR_W
  - access-type enumeration IDLE/WRITE/READ/BAD (2 bits)
  - helper constant FULL_MASK = all DEPTH bits set
- One natural sub-module, coeff_ram_sp: a single bank containing decode, register array, load bitmap, full and error logic.
- The top level instantiates it NUM_BANK times with a generate loop and only slices and packs buses.

Test Plan:
- Reset then read: release reset, Csn=0, Wrn=1, addr=3 on all banks -> next cycle oRdDt=0, oRdValid=4'hF, oAddrErr=0.
- Write then read: bank0 write addr=5, iWrDt=16'h7FFF; next cycle read addr=5 -> oRdDt[15:0]=16'h7FFF one cycle later. Banks 1-3 unchanged at 0.
- Full load: write addresses 0..9 on all banks with data 16'h8000+addr -> oBankFull=4'hF one cycle after the addr-9 write. Streaming reads 0..9 return 16'h8000..16'h8009 with 1-cycle latency.
- Bad address: bank2 write addr=12, data 16'h1234, then read addr=12 -> write discarded, read returns 0 with oRdValid[2]=1, oAddrErr=4'b0100. iClrStat -> oAddrErr=0.
- Clear collision: iClrStat together with a bank1 write to the last unloaded address -> oBankFull[1]=0 afterwards, and a read of that address returns the new data.
- Async reset mid-read stream: pull iRsn low between edges -> oRdDt=0 and oRdValid=0 immediately, before the next edge. Memory reads back 0 after release.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared sizing and access-decode definitions for the FIR coefficient store.
package fir_pkg;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 10;
    localparam int NUM_BANK = 4;
    localparam int ADDR_W   = 4;

    localparam logic [DEPTH-1:0] FULL_MASK = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        BAD   = 2'd3
    } acc_e;

endpackage

// File: rtl/coeff_ram_sp.sv
// One single-port coefficient bank: access decode, word array, load bitmap,
// bank-full and sticky address-error status.
module coeff_ram_sp
    import fir_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     csn_i,
    input  logic                     wrn_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic signed [DATA_W-1:0] wr_dt_i,
    input  logic                     clr_stat_i,
    output logic signed [DATA_W-1:0] rd_dt_o,
    output logic                     rd_vld_o,
    output logic                     full_o,
    output logic                     addr_err_o
);

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic signed [DATA_W-1:0] rd_dt_q, rd_dt_d;
    logic                     rd_vld_q, rd_vld_d;
    logic [DEPTH-1:0]         load_q, load_d;
    logic                     full_q, full_d;
    logic                     err_q, err_d;
    acc_e                     acc;

    always_comb begin
        acc = IDLE;
        if (!csn_i) begin
            if (addr_i >= ADDR_W'(DEPTH)) acc = BAD;
            else if (!wrn_i)              acc = WRITE;
            else                          acc = READ;
        end
    end

    always_comb begin
        rd_dt_d  = rd_dt_q;
        rd_vld_d = 1'b0;
        load_d   = load_q;
        if (acc == READ) begin
            rd_dt_d  = mem_q[addr_i];
            rd_vld_d = 1'b1;
        end
        // An out-of-range read still completes, returning zero.
        if (acc == BAD && wrn_i) begin
            rd_dt_d  = '0;
            rd_vld_d = 1'b1;
        end
        if (acc == WRITE) load_d[addr_i] = 1'b1;
        if (clr_stat_i)   load_d = '0;
        full_d = !clr_stat_i && (load_q == FULL_MASK);
        err_d  = !clr_stat_i && (err_q || acc == BAD);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_dt_q  <= '0;
            rd_vld_q <= 1'b0;
            load_q   <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (acc == WRITE) mem_q[addr_i] <= wr_dt_i;
            rd_dt_q  <= rd_dt_d;
            rd_vld_q <= rd_vld_d;
            load_q   <= load_d;
            full_q   <= full_d;
            err_q    <= err_d;
        end
    end

    assign rd_dt_o    = rd_dt_q;
    assign rd_vld_o   = rd_vld_q;
    assign full_o     = full_q;
    assign addr_err_o = err_q;

endmodule

// File: rtl/coeff_ram_bank.sv
// Four independent coefficient banks on the FIR controller's RAM bus; this
// level only slices the packed control bus and packs the per-bank results.
module coeff_ram_bank
    import fir_pkg::*;
(
    input  logic                         iClk12M,
    input  logic                         iRsn,
    input  logic [NUM_BANK-1:0]          iCsnRam,
    input  logic [NUM_BANK-1:0]          iWrnRam,
    input  logic [NUM_BANK*ADDR_W-1:0]   iAddrRam,
    input  logic [DATA_W-1:0]            iWrDt,
    input  logic                         iClrStat,
    output logic [NUM_BANK*DATA_W-1:0]   oRdDt,
    output logic [NUM_BANK-1:0]          oRdValid,
    output logic [NUM_BANK-1:0]          oBankFull,
    output logic [NUM_BANK-1:0]          oAddrErr
);

    for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
        coeff_ram_sp u_bank (
            .clk_i      (iClk12M),
            .rst_n_i    (iRsn),
            .csn_i      (iCsnRam[gi]),
            .wrn_i      (iWrnRam[gi]),
            .addr_i     (iAddrRam[ADDR_W*gi +: ADDR_W]),
            .wr_dt_i    (iWrDt),
            .clr_stat_i (iClrStat),
            .rd_dt_o    (oRdDt[DATA_W*gi +: DATA_W]),
            .rd_vld_o   (oRdValid[gi]),
            .full_o     (oBankFull[gi]),
            .addr_err_o (oAddrErr[gi])
        );
    end

endmodule

// File: tb/tb_coeff_ram_bank.sv
// Scoreboard bench for coeff_ram_bank: reads push expected words from a
// reference memory; the negedge monitor pops them as oRdValid returns data.
module tb_coeff_ram_bank;

    logic        iClk12M = 1'b0;
    logic        iRsn;
    logic [3:0]  iCsnRam;
    logic [3:0]  iWrnRam;
    logic [15:0] iAddrRam;
    logic [15:0] iWrDt;
    logic        iClrStat;
    logic [63:0] oRdDt;
    logic [3:0]  oRdValid;
    logic [3:0]  oBankFull;
    logic [3:0]  oAddrErr;

    coeff_ram_bank dut (
        .iClk12M   (iClk12M),
        .iRsn      (iRsn),
        .iCsnRam   (iCsnRam),
        .iWrnRam   (iWrnRam),
        .iAddrRam  (iAddrRam),
        .iWrDt     (iWrDt),
        .iClrStat  (iClrStat),
        .oRdDt     (oRdDt),
        .oRdValid  (oRdValid),
        .oBankFull (oBankFull),
        .oAddrErr  (oAddrErr)
    );

    always #5 iClk12M = ~iClk12M;

    typedef struct {
        int          bank;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] mem_m [4][10];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 10; a++) mem_m[b][a] = 16'h0000;
    endtask

    // Drive one bus cycle just after a rising edge; it is captured on the next one.
    task automatic drive(input logic [3:0] csn, input logic [3:0] wrn,
                         input logic [15:0] addr, input logic [15:0] wd, input logic clr);
        exp_t e;
        int   a;
        @(posedge iClk12M);
        #1;
        iCsnRam  = csn;
        iWrnRam  = wrn;
        iAddrRam = addr;
        iWrDt    = wd;
        iClrStat = clr;
        for (int b = 0; b < 4; b++) begin
            if (!csn[b]) begin
                a = int'(addr[4*b +: 4]);
                if (wrn[b]) begin
                    e.bank = b;
                    e.data = (a < 10) ? mem_m[b][a] : 16'h0000;
                    exp_q.push_back(e);
                end else if (a < 10) begin
                    mem_m[b][a] = wd;
                end
            end
        end
    endtask

    task automatic idle();
        drive(4'hF, 4'hF, 16'h0000, 16'h0000, 1'b0);
    endtask

    always @(negedge iClk12M) begin
        exp_t e;
        if (iRsn) begin
            for (int b = 0; b < 4; b++) begin
                if (oRdValid[b]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_vld_b%0d", b), 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("rd_bank_b%0d", b), 64'(b), 64'(e.bank));
                        check($sformatf("rd_data_b%0d", b), 64'(oRdDt[16*b +: 16]), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        iRsn = 1'b0; iCsnRam = 4'hF; iWrnRam = 4'hF;
        iAddrRam = '0; iWrDt = '0; iClrStat = 1'b0;
        clear_model();
        #12;
        check("rst_rddt",  oRdDt,     64'd0);
        check("rst_vld",   64'(oRdValid),  64'd0);
        check("rst_full",  64'(oBankFull), 64'd0);
        check("rst_err",   64'(oAddrErr),  64'd0);
        @(negedge iClk12M);
        iRsn = 1'b1;

        // Read after reset on all banks.
        drive(4'h0, 4'hF, 16'h3333, 16'h0000, 1'b0);
        idle();
        @(negedge iClk12M);
        check("first_rd_vld", 64'(oRdValid), 64'hF);
        check("first_rd_err", 64'(oAddrErr), 64'h0);

        // Write then read on bank 0, neighbours still zero.
        drive(4'hE, 4'hE, 16'h0005, 16'h7FFF, 1'b0);
        drive(4'h0, 4'hF, 16'h5555, 16'h0000, 1'b0);
        idle();

        // Full load of every bank, then streaming reads.
        for (int a = 0; a < 10; a++)
            drive(4'h0, 4'h0, {4{4'(a)}}, 16'h8000 + 16'(a), 1'b0);
        idle();
        @(negedge iClk12M);
        check("full_not_yet", 64'(oBankFull), 64'h0);
        idle();
        @(negedge iClk12M);
        check("full_set", 64'(oBankFull), 64'hF);
        drive(4'hE, 4'hE, 16'h0003, 16'h1111, 1'b0);
        for (int a = 0; a < 10; a++)
            drive(4'h0, 4'hF, {4{4'(a)}}, 16'h0000, 1'b0);
        idle();
        @(negedge iClk12M);
        check("full_after_rewrite", 64'(oBankFull), 64'hF);

        // Out-of-range write and read on bank 2.
        drive(4'hB, 4'hB, 16'h0C00, 16'h1234, 1'b0);
        drive(4'hB, 4'hF, 16'h0C00, 16'h0000, 1'b0);
        drive(4'hB, 4'hF, 16'h0200, 16'h0000, 1'b0);
        idle();
        @(negedge iClk12M);
        check("bad_err", 64'(oAddrErr), 64'h4);
        drive(4'hF, 4'hF, 16'h0000, 16'h0000, 1'b1);
        idle();
        @(negedge iClk12M);
        check("bad_err_clr", 64'(oAddrErr), 64'h0);
        check("full_clr",    64'(oBankFull), 64'h0);

        // Clear together with an out-of-range read on bank 3.
        drive(4'h7, 4'hF, 16'hF000, 16'h0000, 1'b1);
        idle();
        @(negedge iClk12M);
        check("clr_vs_bad_err", 64'(oAddrErr), 64'h0);

        // Clear collides with the write that would complete bank 1.
        for (int a = 0; a < 9; a++)
            drive(4'hD, 4'hD, 16'(a) << 4, 16'hA000 + 16'(a), 1'b0);
        drive(4'hD, 4'hD, 16'h0090, 16'hBEEF, 1'b1);
        idle();
        idle();
        @(negedge iClk12M);
        check("clr_collide_full", 64'(oBankFull), 64'h0);
        drive(4'hD, 4'hF, 16'h0090, 16'h0000, 1'b0);
        drive(4'hD, 4'hF, 16'h0080, 16'h0000, 1'b0);
        idle();
        idle();
        @(negedge iClk12M);
        check("clr_collide_full2", 64'(oBankFull), 64'h0);

        // Async reset in the middle of a read stream.
        drive(4'h0, 4'hF, 16'h1111, 16'h0000, 1'b0);
        drive(4'h0, 4'hF, 16'h2222, 16'h0000, 1'b0);
        @(posedge iClk12M);
        #2;
        check("pre_rst_vld", 64'(oRdValid), 64'hF);
        #1;
        iRsn = 1'b0;
        iCsnRam = 4'hF; iWrnRam = 4'hF; iClrStat = 1'b0;
        exp_q.delete();
        clear_model();
        #1;
        check("midrst_rddt", oRdDt, 64'd0);
        check("midrst_vld",  64'(oRdValid), 64'd0);
        @(negedge iClk12M);
        @(negedge iClk12M);
        iRsn = 1'b1;
        drive(4'h0, 4'hF, 16'h5555, 16'h0000, 1'b0);
        drive(4'h0, 4'hF, 16'h9999, 16'h0000, 1'b0);
        idle();
        idle();
        @(negedge iClk12M);
        check("post_rst_full", 64'(oBankFull), 64'h0);
        check("post_rst_err",  64'(oAddrErr),  64'h0);
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
